// File: rtl/frame_parity_gen.sv
// frame_parity_gen: streaming parity generator over a multi-word frame.
// Words enter on a valid/ready handshake; one parity result per frame leaves
// on a second valid/ready handshake together with the word count and an
// overflow flag.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   input word valid
//   in_ready_o   block can accept an input word (registered)
//   in_data_i    input word, WIDTH bits
//   in_last_i    final word of the frame
//   mode_i       0 = even parity, 1 = odd parity (sampled on first word)
//   par_valid_o  frame result valid (registered)
//   par_ready_i  downstream accepts the result
//   par_o        parity bit for the frame (registered)
//   par_count_o  words in frame, saturating at MAX_WORDS (registered)
//   par_ovf_o    frame held more than MAX_WORDS words (registered)
module frame_parity_gen #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_WORDS = 16,
   parameter bit          ZERO_QUAL = 1'b0,
   localparam int unsigned CW       = $clog2(MAX_WORDS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_last_i,
   input  logic             mode_i,
   output logic             par_valid_o,
   input  logic             par_ready_i,
   output logic             par_o,
   output logic [CW-1:0]    par_count_o,
   output logic             par_ovf_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            acc_q, acc_d;
   logic            nz_q, nz_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            mode_q, mode_d;
   logic            in_ready_q, in_ready_d;
   logic            par_valid_q, par_valid_d;
   logic            par_q, par_d;

   logic            in_xfer;
   logic            out_xfer;
   logic            word_par;
   logic            word_nz;

   assign in_xfer  = in_valid_i & in_ready_q;
   assign out_xfer = par_valid_q & par_ready_i;
   assign word_par = ^in_data_i;
   assign word_nz  = |in_data_i;

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= 1'b0;
         nz_q        <= 1'b0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         mode_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         par_valid_q <= 1'b0;
         par_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         nz_q        <= nz_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         mode_q      <= mode_d;
         in_ready_q  <= in_ready_d;
         par_valid_q <= par_valid_d;
         par_q       <= par_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      nz_d        = nz_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      mode_d      = mode_q;
      in_ready_d  = 1'b0;
      par_valid_d = 1'b0;
      par_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_xfer) begin
               acc_d   = word_par;
               nz_d    = word_nz;
               cnt_d   = CW'(1);
               ovf_d   = 1'b0;
               mode_d  = mode_i;
               state_d = in_last_i ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (in_xfer) begin
               acc_d = acc_q ^ word_par;
               nz_d  = nz_q | word_nz;
               // Extra words still fold into acc/nz; only the count saturates
               if (cnt_q == CW'(MAX_WORDS)) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
               if (in_last_i) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_xfer) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered copies of what the next state implies
      in_ready_d  = (state_d != HOLD);
      par_valid_d = (state_d == HOLD);
      par_d       = (ZERO_QUAL && !nz_d) ? 1'b0 : (acc_d ^ mode_d);
   end

   assign in_ready_o  = in_ready_q;
   assign par_valid_o = par_valid_q;
   assign par_o       = par_q;
   assign par_count_o = cnt_q;
   assign par_ovf_o   = ovf_q;

endmodule
